// File: rtl/apb_stream_fifo_slave.sv
// APB register slave with a TX and an RX 16-bit stream FIFO.
// Zero-wait-state access, registered level interrupt.

module apb_stream_fifo_slave_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        pclk,
  input  logic        prst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic [4:0]  cnt,
  output logic        full,
  output logic        empty
);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  assign full  = (cnt == 5'(DEPTH));
  assign empty = (cnt == 5'd0);
  assign rdata = empty ? 16'd0 : mem[rptr];

  always_ff @(posedge pclk) begin
    if (push) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 5'd1;
        2'b01:   cnt <= cnt - 5'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

module apb_stream_fifo_slave #(
  parameter int DEPTH = 8,
  parameter int UDLY  = 1
) (
  input  logic        pclk,
  input  logic        prst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [7:0]  paddr,
  input  logic [15:0] pwdata,
  output logic [15:0] prdata,
  output logic [15:0] o_data,
  output logic        o_valid,
  input  logic        i_ready,
  input  logic [15:0] i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 ||
      (DEPTH & (DEPTH - 1)) != 0 ||
      UDLY < 0) begin : g_bad_cfg
    $error("apb_stream_fifo_slave: bad parameters");
  end

  logic [3:0]  ctrl;
  logic        tx_ovf;
  logic        rx_udf;

  logic        wr;
  logic        rd;
  logic        a_ctrl;
  logic        a_stat;
  logic        a_txd;
  logic        a_rxd;
  logic        a_lvl;

  logic        tx_en;
  logic        rx_en;
  logic        ie_rx;
  logic        ie_tx;

  logic        tx_req;
  logic        tx_push;
  logic        tx_pop;
  logic        tx_flush;
  logic [4:0]  tx_cnt;
  logic        tx_full;
  logic        tx_empty;

  logic        rx_req;
  logic        rx_push;
  logic        rx_pop;
  logic        rx_flush;
  logic [15:0] rx_head;
  logic [4:0]  rx_cnt;
  logic        rx_full;
  logic        rx_empty;

  logic        unused_pwdata;

  assign unused_pwdata = ^pwdata[15:6];

  assign wr = psel & penable & pwrite;
  assign rd = psel & penable & ~pwrite;

  assign a_ctrl = (paddr == 8'h00);
  assign a_stat = (paddr == 8'h01);
  assign a_txd  = (paddr == 8'h02);
  assign a_rxd  = (paddr == 8'h03);
  assign a_lvl  = (paddr == 8'h04);

  assign tx_en = ctrl[0];
  assign rx_en = ctrl[1];
  assign ie_rx = ctrl[2];
  assign ie_tx = ctrl[3];

  // Fullness/emptiness are judged on the state at cycle start.
  assign tx_req   = wr & a_txd;
  assign tx_push  = tx_req & ~tx_full;
  assign o_valid  = tx_en & ~tx_empty;
  assign tx_pop   = o_valid & i_ready;
  assign tx_flush = wr & a_ctrl & pwdata[4];

  assign o_ready  = rx_en & ~rx_full;
  assign rx_push  = i_valid & o_ready;
  assign rx_req   = rd & a_rxd;
  assign rx_pop   = rx_req & ~rx_empty;
  assign rx_flush = wr & a_ctrl & pwdata[5];

  apb_stream_fifo_slave_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_tx (
    .pclk  (pclk),
    .prst_n(prst_n),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (tx_flush),
    .wdata (pwdata),
    .rdata (o_data),
    .cnt   (tx_cnt),
    .full  (tx_full),
    .empty (tx_empty)
  );

  apb_stream_fifo_slave_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_rx (
    .pclk  (pclk),
    .prst_n(prst_n),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (rx_flush),
    .wdata (i_data),
    .rdata (rx_head),
    .cnt   (rx_cnt),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_comb begin
    prdata = 16'd0;
    if (psel) begin
      unique case (1'b1)
        a_ctrl:  prdata = {12'd0, ctrl};
        a_stat:  prdata = {10'd0, rx_udf, tx_ovf,
                           rx_empty, rx_full,
                           tx_empty, tx_full};
        a_rxd:   prdata = rx_head;
        a_lvl:   prdata = {3'd0, rx_cnt,
                           3'd0, tx_cnt};
        default: prdata = 16'd0;
      endcase
    end
  end

  // A new event in the same cycle as its W1C clear keeps the flag set.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      ctrl   <= 4'd0;
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr & a_ctrl) begin
        ctrl <= pwdata[3:0];
      end
      tx_ovf <= (tx_req & tx_full) |
                (tx_ovf & ~(wr & a_stat & pwdata[4]));
      rx_udf <= (rx_req & rx_empty) |
                (rx_udf & ~(wr & a_stat & pwdata[5]));
      irq    <= (ie_rx & ~rx_empty) |
                (ie_tx & tx_empty) |
                tx_ovf | rx_udf;
    end
  end

endmodule

// File: tb/tb_apb_stream_fifo_slave.sv
// Randomized bench for apb_stream_fifo_slave.
// Checks every cycle against a queue-level model.

module tb_apb_stream_fifo_slave;

  localparam int DEPTH = 8;

  logic        pclk = 1'b0;
  logic        prst_n = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [7:0]  paddr = 8'd0;
  logic [15:0] pwdata = 16'd0;
  logic [15:0] prdata;
  logic [15:0] o_data;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [15:0] i_data = 16'd0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        irq;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];
  logic [3:0]  m_ctrl;
  logic        m_ovf;
  logic        m_udf;
  logic        m_irq;

  always #5 pclk = ~pclk;

  apb_stream_fifo_slave #(
    .DEPTH(DEPTH),
    .UDLY (1)
  ) dut (
    .pclk   (pclk),
    .prst_n (prst_n),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .paddr  (paddr),
    .pwdata (pwdata),
    .prdata (prdata),
    .o_data (o_data),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .i_data (i_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .irq    (irq)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    tx_q.delete();
    rx_q.delete();
    m_ctrl = 4'd0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_irq  = 1'b0;
  endtask

  function automatic logic [15:0] exp_prdata();
    logic [4:0] tc;
    logic [4:0] rc;
    tc = 5'(tx_q.size());
    rc = 5'(rx_q.size());
    if (!psel) return 16'd0;
    case (paddr)
      8'h00: return {12'd0, m_ctrl};
      8'h01: return {10'd0, m_udf, m_ovf,
                     rc == 0, rc == DEPTH,
                     tc == 0, tc == DEPTH};
      8'h03: return (rc == 0) ? 16'd0 : rx_q[0];
      8'h04: return {3'd0, rc, 3'd0, tc};
      default: return 16'd0;
    endcase
  endfunction

  task automatic compare_outputs();
    check("prdata", prdata, exp_prdata());
    check("o_valid", o_valid,
          m_ctrl[0] && tx_q.size() > 0);
    if (tx_q.size() > 0) check("o_data", o_data, tx_q[0]);
    check("o_ready", o_ready,
          m_ctrl[1] && rx_q.size() < DEPTH);
    check("irq", irq, m_irq);
  endtask

  task automatic m_update();
    bit wr, rd, txf, rxf, tfull, rempty;
    bit tpop, rpush, irq_n;
    wr = psel && penable && pwrite;
    rd = psel && penable && !pwrite;
    tfull  = (tx_q.size() == DEPTH);
    rempty = (rx_q.size() == 0);
    irq_n = (m_ctrl[2] && !rempty) ||
            (m_ctrl[3] && tx_q.size() == 0) ||
            m_ovf || m_udf;
    txf = wr && paddr == 8'h00 && pwdata[4];
    rxf = wr && paddr == 8'h00 && pwdata[5];
    tpop  = m_ctrl[0] && tx_q.size() > 0 && i_ready;
    rpush = i_valid && m_ctrl[1] &&
            rx_q.size() < DEPTH;
    if (txf) tx_q.delete();
    else begin
      if (tpop) void'(tx_q.pop_front());
      if (wr && paddr == 8'h02 && !tfull)
        tx_q.push_back(pwdata);
    end
    if (rxf) rx_q.delete();
    else begin
      if (rd && paddr == 8'h03 && !rempty)
        void'(rx_q.pop_front());
      if (rpush) rx_q.push_back(i_data);
    end
    m_ovf = (wr && paddr == 8'h02 && tfull) ||
            (m_ovf && !(wr && paddr == 8'h01 && pwdata[4]));
    m_udf = (rd && paddr == 8'h03 && rempty) ||
            (m_udf && !(wr && paddr == 8'h01 && pwdata[5]));
    if (wr && paddr == 8'h00) m_ctrl = pwdata[3:0];
    m_irq = irq_n;
  endtask

  task automatic step();
    #1;
    compare_outputs();
    @(posedge pclk);
    m_update();
    @(negedge pclk);
  endtask

  task automatic idle_bus();
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic do_reset();
    idle_bus();
    paddr = 0; pwdata = 0;
    i_ready = 0; i_valid = 0; i_data = 0;
    prst_n = 0;
    #1;
    m_reset();
    check("rst_o_valid", o_valid, 0);
    check("rst_o_ready", o_ready, 0);
    check("rst_irq", irq, 0);
    check("rst_o_data", o_data, 0);
    check("rst_prdata", prdata, 0);
    @(negedge pclk);
    prst_n = 1;
  endtask

  task automatic apb_wr(input logic [7:0] a,
                        input logic [15:0] d);
    psel = 1; penable = 0; pwrite = 1;
    paddr = a; pwdata = d;
    step();
    penable = 1;
    step();
    idle_bus();
  endtask

  task automatic apb_rd(input string tag,
                        input logic [7:0] a,
                        input logic [15:0] exp);
    psel = 1; penable = 0; pwrite = 0; paddr = a;
    step();
    penable = 1;
    #1 check(tag, prdata, exp);
    step();
    idle_bus();
  endtask

  initial begin
    // Reset state
    do_reset();
    apb_rd("stat_rst", 8'h01, 16'h000A);
    apb_rd("lvl_rst", 8'h04, 16'h0000);
    check("irq_rst", irq, 0);

    // Fill TX while stalled, overflow, then drain
    for (int i = 1; i <= 8; i++)
      apb_wr(8'h02, 16'(16'h1111 * i));
    apb_wr(8'h02, 16'h9999);
    apb_rd("stat_full", 8'h01, 16'h0019);
    apb_rd("lvl_full", 8'h04, 16'h0008);
    check("stall_o_valid", o_valid, 0);
    i_ready = 1;
    apb_wr(8'h00, 16'h0001);
    for (int i = 1; i <= 8; i++) begin
      #1 check("drain_data", o_data, 32'h1111 * i);
      check("drain_valid", o_valid, 1);
      step();
    end
    #1 check("drain_done", o_valid, 0);
    i_ready = 0;

    // RX path, interrupt latency, underflow
    do_reset();
    apb_wr(8'h00, 16'h0006);
    i_valid = 1; i_data = 16'hA001;
    step();
    i_data = 16'hA002;
    #1 check("irq_lat0", irq, 0);
    step();
    i_valid = 0;
    #1 check("irq_rise", irq, 1);
    apb_rd("rx_pop0", 8'h03, 16'hA001);
    apb_rd("rx_pop1", 8'h03, 16'hA002);
    apb_rd("rx_udf", 8'h03, 16'h0000);
    apb_rd("stat_udf", 8'h01, 16'h002A);
    apb_wr(8'h01, 16'h0020);
    #1 check("irq_hold", irq, 1);
    step();
    #1 check("irq_fall", irq, 0);
    apb_rd("stat_clr", 8'h01, 16'h000A);

    // Push into full FIFO while it pops
    do_reset();
    for (int i = 0; i < 8; i++)
      apb_wr(8'h02, 16'(16'h2222 + i));
    apb_wr(8'h00, 16'h0001);
    psel = 1; penable = 0; pwrite = 1;
    paddr = 8'h02; pwdata = 16'hBEEF;
    step();
    penable = 1; i_ready = 1;
    step();
    idle_bus(); i_ready = 0;
    apb_rd("lvl_ovf", 8'h04, 16'h0007);
    apb_rd("stat_ovf", 8'h01, 16'h0018);

    // Flush with pending output
    do_reset();
    for (int i = 0; i < 5; i++)
      apb_wr(8'h02, 16'(16'h3000 + i));
    i_ready = 1;
    apb_wr(8'h00, 16'h0011);
    #1 check("flush_valid", o_valid, 0);
    apb_rd("flush_lvl", 8'h04, 16'h0000);
    apb_rd("flush_ctrl", 8'h00, 16'h0001);
    i_ready = 0;

    // Asynchronous reset mid-stream
    do_reset();
    apb_wr(8'h00, 16'h0002);
    i_valid = 1;
    for (int i = 0; i < 4; i++) begin
      i_data = 16'(16'h4000 + i);
      step();
    end
    i_valid = 0;
    for (int i = 0; i < 4; i++)
      apb_wr(8'h02, 16'(16'h5000 + i));
    apb_wr(8'h00, 16'h0007);
    step();
    #1 check("pre_valid", o_valid, 1);
    check("pre_ready", o_ready, 1);
    check("pre_irq", irq, 1);
    #1 prst_n = 0;
    #1 check("arst_valid", o_valid, 0);
    check("arst_ready", o_ready, 0);
    check("arst_irq", irq, 0);
    m_reset();
    @(negedge pclk);
    prst_n = 1;
    apb_rd("arst_lvl", 8'h04, 16'h0000);

    // Random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      psel    = ($urandom_range(0, 3) != 0);
      penable = 1'($urandom_range(0, 1));
      pwrite  = 1'($urandom_range(0, 1));
      paddr   = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 15) == 0)
        paddr = 8'($urandom);
      pwdata  = 16'($urandom);
      if (paddr == 8'h00 &&
          $urandom_range(0, 7) != 0)
        pwdata[5:4] = 2'b00;
      i_ready = 1'($urandom_range(0, 1));
      i_valid = 1'($urandom_range(0, 1));
      i_data  = 16'($urandom);
      step();
    end
    idle_bus();
    i_valid = 0;
    i_ready = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_stream_fifo_slave.md
Name: apb_stream_fifo_slave

Overview:
- APB peripheral on one select line (psel0..psel3) of the SPI/I2C-to-APB bridge: consumes psel/penable/pwrite/paddr/pwdata, returns prdata.
- Contains a TX FIFO, filled by APB writes and drained to a valid/ready stream output, and an RX FIFO, filled from a valid/ready stream input and drained by APB reads.
- Provides control, status and level registers plus a registered interrupt.
- Zero-wait-state slave; there is no pready.

Parameters:
- DEPTH, 8: entries per FIFO; power of two, 2..16.
- UDLY, 1: simulation delay on registered assignments; no functional effect.

Ports:
- pclk  in  1  APB clock; all logic on rising edge.
- prst_n  in  1  asynchronous active-low reset.
- psel  in  1  slave select from bridge.
- penable  in  1  APB access phase.
- pwrite  in  1  1=write, 0=read.
- paddr  in  8  register address.
- pwdata  in  16  write data.
- prdata  out  16  read data to bridge.
- o_data  out  16  TX stream data (FIFO head).
- o_valid  out  1  TX stream valid.
- i_ready  in  1  TX stream ready from consumer.
- i_data  in  16  RX stream data.
- i_valid  in  1  RX stream valid.
- o_ready  out  1  RX stream ready.
- irq  out  1  level interrupt, registered.

Behaviour:
- Reset (prst_n low, asynchronous): both FIFOs empty, all pointers and counts 0, CTRL=0, sticky flags 0, irq=0, o_valid=0, o_ready=0. prdata and o_data read 0.
- APB access phase is psel & penable. A write commits on the pclk edge ending that phase. A read pop also commits on that edge.
- prdata is combinational from paddr while psel=1; it is 0 when psel=0.
- Register map (unmapped addresses: reads return 0, writes ignored):
  - 0x00 CTRL, rw:
    - [0] tx_en.
    - [1] rx_en.
    - [2] ie_rx_nempty.
    - [3] ie_tx_empty.
    - [4] tx_flush: self-clearing, reads 0.
    - [5] rx_flush: self-clearing, reads 0.
  - 0x01 STATUS:
    - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty.
    - [4] tx_ovf: sticky, write-1-to-clear.
    - [5] rx_udf: sticky, write-1-to-clear.
    - Other bits read 0.
  - 0x02 TXDATA, write-only: pushes pwdata. Reads return 0.
  - 0x03 RXDATA, read-only: returns the RX head and pops it. Writes ignored.
  - 0x04 LEVEL, ro: [4:0] tx_cnt, [12:8] rx_cnt.
- TX FIFO:
  - Push on an APB write to 0x02.
  - Push when full at cycle start: data dropped, tx_ovf set. This holds even if a pop occurs in the same cycle.
  - o_valid = tx_en & ~tx_empty. o_data = head entry.
  - Pop when o_valid & i_ready.
  - Push and pop in the same cycle (not full): both occur; count unchanged.
  - tx_en=0 stalls output only; APB pushes are still accepted.
- RX FIFO:
  - o_ready = rx_en & ~rx_full.
  - Push when i_valid & o_ready.
  - APB read of 0x03 when rx_empty at cycle start: prdata=0, rx_udf set, no pointer change. A stream push in the same cycle still occurs.
  - Push and pop in the same cycle: both occur; count unchanged.
- Flush: a CTRL write with [4] or [5] set resets the respective pointers and count on that edge. Flush wins over any push/pop to that FIFO in the same cycle. Other CTRL bits are written normally.
- Sticky-flag precedence: when set and W1C clear coincide, set wins.
- Pointers wrap modulo DEPTH. Counts range 0..DEPTH: full = (cnt==DEPTH), empty = (cnt==0).
- irq is registered with 1-cycle latency: irq <= (ie_rx_nempty & ~rx_empty) | (ie_tx_empty & tx_empty) | tx_ovf | rx_udf.
- Reset asserted mid-transfer: all state returns immediately to the reset values; the interrupted transfer is lost.

Test Plan:
- Reset, then read 0x01 -> 0x000A (tx_empty, rx_empty). Read 0x04 -> 0x0000. irq=0.
- With CTRL=0 (tx_en=0), write 0x1111..0x8888 to 0x02 (8 writes), then a 9th write 0x9999 -> STATUS=0x0019, LEVEL=0x0008, o_valid=0. Set CTRL=0x0001 with i_ready=1 -> o_data sequence 0x1111..0x8888 on consecutive cycles; 0x9999 never appears.
- CTRL=0x0006, drive i_valid with 0xA001, 0xA002 -> irq rises 1 cycle after the first push. Two reads of 0x03 return 0xA001 then 0xA002. A third read returns 0 and sets STATUS[5]. Write 0x0020 to 0x01 -> STATUS[5]=0; irq falls the next cycle.
- TX full (8 entries), tx_en=1, i_ready=1, plus an APB push in the same cycle -> entry dropped, tx_ovf=1, tx_cnt=7 after that edge.
- With 5 entries queued, write CTRL=0x0011 while i_ready=1 -> tx_cnt=0 and o_valid=0 on the next cycle; CTRL reads 0x0001.
- Assert prst_n low mid-stream with 4 entries queued in each FIFO -> o_valid=0, o_ready=0, irq=0 immediately, without waiting for a clock edge; LEVEL=0 after release.
